addsub_pipe: RTL and testbench

Parametrised, pipelined carry-propagate adder/subtractor for the execute and multiply-accumulate datapath. The operand width is split into `STAGES` equal slices, one slice per pipeline stage, with the slice carry registered between stages. Throughput is one operation per cycle. The block uses a valid/ready handshake on input and output, a flush, and a destination tag that travels with each operation. It replaces the single-cycle 64-bit lookahead adder on paths where timing, not latency, is the constraint.

---
 rtl/addsub_pipe.sv | 156 +++++++++++++++
 tb/tb_addsub_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined carry-propagate adder/subtractor.
// The operand is cut into STAGES slices of SW bits. One slice is added per
// stage, and the slice carry is registered between stages. Operand slices
// that are still to be added travel forward in skew registers. Result slices
// that are already done travel forward in de-skew registers.
// The output registers are the last stage, and they use a valid/ready
// handshake with flush and tag passthrough.
// Optional feature: define ADDSUB_PIPE_SAT_EN to add the sat port and
// signed-overflow saturation.
module addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int          SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage registers: index k is the state after slice k has been added.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             v_q   [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic             ovf_q;

  // Stage inputs and next-state values.
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic [TAG_W-1:0] tag_in [STAGES];
  logic [WIDTH-1:0] s_nx   [STAGES];
  logic             c_nx   [STAGES];
  logic [SW:0]      sl;
  logic             msb_cin;
  logic             ovf_nx;
  logic [WIDTH-1:0] res_nx;

`ifdef ADDSUB_PIPE_SAT_EN
  logic             sat_q  [STAGES];
  logic             sat_in [STAGES];
`endif

  logic adv;
  logic take;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv & !flush;
  assign take      = in_valid & in_ready;

  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign out_tag   = tag_q[LAST];

  // Per-stage slice add. Stage 0 takes its inputs from the ports; every later
  // stage takes them from the register of the stage before it.
  always_comb begin
    sl        = '0;
    a_in[0]   = a;
    b_in[0]   = sub ? ~b : b;
    c_in[0]   = sub ^ cin;
    s_in[0]   = '0;
    tag_in[0] = tag;
`ifdef ADDSUB_PIPE_SAT_EN
    sat_in[0] = sat;
`endif
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      s_in[k]   = s_q[k-1];
      tag_in[k] = tag_q[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
      sat_in[k] = sat_q[k-1];
`endif
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      sl = {1'b0, a_in[k][k*SW +: SW]} + {1'b0, b_in[k][k*SW +: SW]}
         + {{SW{1'b0}}, c_in[k]};
      s_nx[k]             = s_in[k];
      s_nx[k][k*SW +: SW] = sl[SW-1:0];
      c_nx[k]             = sl[SW];
    end
    // The carry into the MSB can be recovered from the operand and sum bits.
    msb_cin = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nx[LAST][WIDTH-1];
    ovf_nx  = msb_cin ^ c_nx[LAST];
    res_nx  = s_nx[LAST];
`ifdef ADDSUB_PIPE_SAT_EN
    // On overflow both operands share one sign, and that sign gives the
    // direction of the overflow.
    if (sat_in[LAST] && ovf_nx)
      res_nx = a_in[LAST][WIDTH-1] ? {1'b1, {WIDTH-1{1'b0}}}
                                   : {1'b0, {WIDTH-1{1'b1}}};
`endif
  end

  // Pipeline registers. Flush wins over advance, and every stage shifts or
  // holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        tag_q[k] <= '0;
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned k = 0; k < STAGES; k++) v_q[k] <= 1'b0;
    end else if (adv) begin
      v_q[0] <= take;
      for (int unsigned k = 1; k < STAGES; k++) v_q[k] <= v_q[k-1];
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        s_q[k]   <= (k == LAST) ? res_nx : s_nx[k];
        c_q[k]   <= c_nx[k];
        tag_q[k] <= tag_in[k];
`ifdef ADDSUB_PIPE_SAT_EN
        sat_q[k] <= sat_in[k];
`endif
      end
      ovf_q <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe with WIDTH=64 and STAGES=4.
// It runs a table of single operations and checks their latency, then runs
// hand-written sequences for reset, backpressure and flush.
module tb_addsub_pipe;

  localparam int W = 64;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [T-1:0] tag = '0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic [T-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  addsub_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation and wait for its result. The edge that captures the
  // operation counts as edge 1, so the result must appear after edge 4.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic vsub, input logic vsat, input logic [T-1:0] vtag,
                        input logic [W-1:0] es, input logic ecout, input logic eovf);
    int  edges;
    bit  seen;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; sat = vsat; tag = vtag; in_valid = 1'b1;
    #1 chk({name, ".in_ready"}, W'(in_ready), W'(1));
    edges = 0;
    seen  = 0;
    while (edges < 20 && !seen) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) seen = 1;
    end
    chk({name, ".latency"}, W'(edges), W'(4));
    chk({name, ".s"}, s, es);
    chk({name, ".cout"}, W'(cout), W'(ecout));
    chk({name, ".ovf"}, W'(ovf), W'(eovf));
    chk({name, ".tag"}, W'(out_tag), W'(vtag));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[11];

  logic [W-1:0] bp_exp [1:6];

  initial begin : main
    int n;
    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[2]  = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4]  = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 64'h2345_6789_ABCD_F002, 1'b0, 1'b0};
    vecs[5]  = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h6, 1'b1, 1'b0};
    vecs[6]  = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[7]  = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[9]  = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[10] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.s", s, '0);
    chk("rst.cout", W'(cout), W'(0));
    chk("rst.ovf", W'(ovf), W'(0));
    chk("rst.out_tag", W'(out_tag), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst.in_ready", W'(in_ready), W'(1));

    // Table-driven single operations
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             1'b0, T'(i + 1), vecs[i].s, vecs[i].cout, vecs[i].ovf);

`ifdef ADDSUB_PIPE_SAT_EN
    run_op("sat_on", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1, T'(20),
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op("sat_off", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, T'(21),
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sat_neg", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b1, T'(22),
           64'h8000_0000_0000_0000, 1'b1, 1'b1);
`endif

    // Backpressure: six back-to-back operations with a 3-cycle output stall
    for (int i = 1; i <= 6; i++)
      bp_exp[i] = (64'h00FF_FFFF_FFFF_FFFF + 64'(i)) + 64'(i) * 64'h100;
    @(negedge clk);
    out_ready = 1'b1;
    fork
      begin : drv
        for (int i = 1; i <= 6; i++) begin
          int tries;
          bit acc;
          a = 64'h00FF_FFFF_FFFF_FFFF + 64'(i);
          b = 64'(i) * 64'h100;
          cin = 1'b0; sub = 1'b0; sat = 1'b0; tag = T'(i); in_valid = 1'b1;
          tries = 0;
          acc = 0;
          while (!acc && tries < 50) begin
            #4 acc = in_valid && in_ready;
            @(posedge clk);
            tries++;
            if (!acc) @(negedge clk);
          end
          if (!acc) chk("bp.accept_timeout", W'(tries), W'(0));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : mon
        int got;
        int cyc;
        bit stalled;
        logic [W-1:0] snap_s;
        logic [T-1:0] snap_t;
        got = 0;
        cyc = 0;
        stalled = 0;
        while (got < 6 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (out_valid) begin
            if (!stalled) begin
              stalled = 1;
              out_ready = 1'b0;
              snap_s = s;
              snap_t = out_tag;
              for (int j = 0; j < 3; j++) begin
                #1 chk("bp.in_ready_stall", W'(in_ready), W'(0));
                @(negedge clk);
                chk("bp.hold_valid", W'(out_valid), W'(1));
                chk("bp.hold_s", s, snap_s);
                chk("bp.hold_tag", W'(out_tag), W'(snap_t));
              end
              out_ready = 1'b1;
            end
            chk("bp.tag_order", W'(out_tag), W'(got + 1));
            chk("bp.s", s, bp_exp[got + 1]);
            got++;
          end
        end
        chk("bp.count", W'(got), W'(6));
        n = 0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          if (out_valid) n++;
        end
        chk("bp.no_extra", W'(n), W'(0));
      end
    join

    // Reset mid-flight: one result at the output and three behind it
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 64'(i + 1); b = 64'h1; cin = 1'b0; sub = 1'b0; tag = T'(i + 10); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 chk("mrst.pre_valid", W'(out_valid), W'(1));
    chk("mrst.pre_s", s, 64'h2);
    #1 rst = 1'b1;
    #1 chk("mrst.out_valid", W'(out_valid), W'(0));
    chk("mrst.s", s, '0);
    chk("mrst.out_tag", W'(out_tag), W'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst.in_ready", W'(in_ready), W'(1));
    n = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mrst.no_output", W'(n), W'(0));

    // Flush: three in flight plus one presented in the flush cycle
    for (int i = 0; i < 3; i++) begin
      a = 64'(i + 100); b = 64'h5; cin = 1'b0; sub = 1'b0; tag = T'(i + 1); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    a = 64'h77; tag = T'(4); in_valid = 1'b1; flush = 1'b1;
    #1 chk("flush.in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    n = 0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid) n++;
      @(negedge clk);
    end
    chk("flush.no_output", W'(n), W'(0));
    run_op("post_flush", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0, T'(9),
           64'h0000_0001_0000_0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
